// File: rtl/lu_pkg.sv
// ============================================================================
// Package     : lu_pkg
// Description : Shared types and widths for the sonar logic-unit arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package lu_pkg;

    localparam int LU_W = 16;

    typedef enum logic [2:0] {
        LU_AND  = 3'b000,
        LU_NAND = 3'b001,
        LU_OR   = 3'b010,
        LU_NOR  = 3'b011,
        LU_XOR  = 3'b100,
        LU_XNOR = 3'b101,
        LU_NOTA = 3'b110,
        LU_NOTB = 3'b111
    } lu_op_e;

    typedef enum logic {
        LU_IDLE = 1'b0,
        LU_RESP = 1'b1
    } lu_state_e;

endpackage

`default_nettype wire

// File: rtl/mux16.sv
// ============================================================================
// Module      : mux16
// Description : 16-bit logic unit, eight bitwise functions selected by op.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mux16
    import lu_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [LU_W-1:0] a,
    input  logic [LU_W-1:0] b,
    output logic [LU_W-1:0] y
);

    always_comb begin
        y = '0;
        case (lu_op_e'(op))
            LU_AND:  y = a & b;
            LU_NAND: y = ~(a & b);
            LU_OR:   y = a | b;
            LU_NOR:  y = ~(a | b);
            LU_XOR:  y = a ^ b;
            LU_XNOR: y = ~(a ^ b);
            LU_NOTA: y = ~a;
            LU_NOTB: y = ~b;
            default: y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; search starts after last_grant.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int w_best;

    // Rotated distance 0 belongs to last_grant+1; smallest distance wins.
    always_comb begin
        w_best = NREQ;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (valid[i] && (((i + NREQ - 1 - int'(last_grant)) % NREQ) < w_best)) begin
                w_best = (i + NREQ - 1 - int'(last_grant)) % NREQ;
                idx    = i[IDW-1:0];
                any    = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = any && (idx == i[IDW-1:0]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
// ============================================================================
// Module      : logic_unit_arbiter
// Description : Round-robin sharing of one 16-bit logic unit between NREQ
//               requesters; registered result returned with requester ID.
//               Optional macro LU_OPCOUNT_EN adds a saturating op_count port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module logic_unit_arbiter
    import lu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [LU_W*NREQ-1:0] req_a,
    input  logic [LU_W*NREQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [LU_W-1:0]      rsp_data
`ifdef LU_OPCOUNT_EN
    ,
    output logic [15:0]          op_count
`endif
);

    localparam logic [IDW-1:0] c_LAST_INIT = IDW'(NREQ - 1);

    lu_state_e         r_state;
    logic [IDW-1:0]    r_last_grant;
    logic [IDW-1:0]    r_rsp_id;
    logic [LU_W-1:0]   r_rsp_data;

    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_idx;
    logic              w_any;
    logic              w_can_accept;
    logic              w_xfer;
    logic [2:0]        w_op;
    logic [LU_W-1:0]   w_a;
    logic [LU_W-1:0]   w_b;
    logic [LU_W-1:0]   w_y;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .valid      (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .idx        (w_idx),
        .any        (w_any)
    );

    // A full response register frees up in the same cycle it is consumed.
    assign w_can_accept = (r_state == LU_IDLE) || rsp_ready;
    assign w_xfer       = w_any && w_can_accept && !reset;
    assign req_ready    = w_xfer ? w_grant : '0;

    always_comb begin
        w_op = '0;
        w_a  = '0;
        w_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == i[IDW-1:0]) begin
                w_op = req_op[3*i +: 3];
                w_a  = req_a[LU_W*i +: LU_W];
                w_b  = req_b[LU_W*i +: LU_W];
            end
        end
    end

    mux16 u_mux16 (
        .op (w_op),
        .a  (w_a),
        .b  (w_b),
        .y  (w_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= LU_IDLE;
            r_last_grant <= c_LAST_INIT;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
        end else if (w_xfer) begin
            r_state      <= LU_RESP;
            r_last_grant <= w_idx;
            r_rsp_id     <= w_idx;
            r_rsp_data   <= w_y;
        end else if ((r_state == LU_RESP) && rsp_ready) begin
            r_state      <= LU_IDLE;
        end
    end

    assign rsp_valid = (r_state == LU_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

`ifdef LU_OPCOUNT_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_count <= '0;
        end else if (w_xfer && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
// ============================================================================
// Module      : tb_logic_unit_arbiter
// Description : Directed bench for logic_unit_arbiter with a per-cycle reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_logic_unit_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [3*NREQ-1:0]    req_op;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [15:0]          rsp_data;
`ifdef LU_OPCOUNT_EN
    logic [15:0]          op_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_init  = 1'b0;
    bit          m_valid = 1'b0;
    logic [15:0] m_data  = '0;
    int          m_id    = 0;
    int          m_last  = NREQ - 1;
    int          m_cnt   = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef LU_OPCOUNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    function automatic logic [15:0] lu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return ~b;
        endcase
    endfunction

    function automatic int winner();
        int c;
        if (reset) return -1;
        if (m_valid && !rsp_ready) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r;
        int w;
        r = '0;
        w = winner();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int w;
        if (reset) begin
            m_init  = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = 0;
            m_last  = NREQ - 1;
            m_cnt   = 0;
        end else if (m_init) begin
            w = winner();
            if (w >= 0) begin
                m_data  = lu(req_op[3*w +: 3], req_a[16*w +: 16], req_b[16*w +: 16]);
                m_id    = w;
                m_valid = 1'b1;
                m_last  = w;
                if (m_cnt < 65535) m_cnt++;
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_req_ready", 32'(req_ready), 32'(exp_ready()));
            chk("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("model_rsp_id",    32'(rsp_id),    32'(m_id));
            chk("model_rsp_data",  32'(rsp_data),  32'(m_data));
`ifdef LU_OPCOUNT_EN
            chk("model_op_count",  32'(op_count),  32'(m_cnt));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setreq(input int i, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        req_valid[i]       = 1'b1;
        req_op[3*i +: 3]   = op;
        req_a[16*i +: 16]  = a;
        req_b[16*i +: 16]  = b;
    endtask

    logic [15:0] exp_ops [8];

    initial begin
        exp_ops = '{16'h000F, 16'hFFF0, 16'h0FFF, 16'hF000,
                    16'h0FF0, 16'hF00F, 16'hFF00, 16'hF0F0};
        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        step();
        step();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data",  32'(rsp_data),  32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);

        // single request
        reset = 1'b0;
        setreq(0, 3'b000, 16'hF0F0, 16'hFF00);
        #1;
        chk("single_req_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_id",    32'(rsp_id),    32'd0);
        chk("single_rsp_data",  32'(rsp_data),  32'hF000);

        // all ops on requester 1
        for (int op = 0; op < 8; op++) begin
            setreq(1, 3'(op), 16'h00FF, 16'h0F0F);
            step();
            chk("op_rsp_data", 32'(rsp_data), 32'(exp_ops[op]));
            chk("op_rsp_id",   32'(rsp_id),   32'd1);
        end
        req_valid = '0;
        step();

        // round robin with all requesters valid
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) setreq(i, 3'(i), 16'(i * 16'h1111), 16'h5A5A);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_rsp_id", 32'(rsp_id), 32'(k % NREQ));
        end
        req_valid = '0;

        // backpressure with requester 2 pending
        reset = 1'b1;
        step();
        reset     = 1'b0;
        rsp_ready = 1'b0;
        setreq(0, 3'b010, 16'h1000, 16'h0001);
        step();
        req_valid = '0;
        setreq(2, 3'b100, 16'h1234, 16'h00FF);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data",  32'(rsp_data),  32'h1001);
        end
        rsp_ready = 1'b1;
        #1;
        chk("release_req_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        chk("release_rsp_id",   32'(rsp_id),   32'd2);
        chk("release_rsp_data", 32'(rsp_data), 32'h12CB);
        step();
        chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("drain_rsp_id",    32'(rsp_id),    32'd2);

        // reset while a response is held
        rsp_ready = 1'b0;
        setreq(3, 3'b110, 16'h00FF, 16'h0000);
        step();
        req_valid = 4'b1111;
        reset     = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        step();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("rst_first_grant", 32'(req_ready), 32'b0001);
        step();
        chk("rst_first_id", 32'(rsp_id), 32'd0);
        req_valid = '0;

        // requester withdraws before being granted
        rsp_ready = 1'b0;
        setreq(2, 3'b001, 16'hAAAA, 16'h5555);
        step();
        setreq(1, 3'b011, 16'h0F00, 16'h00F0);
        step();
        req_valid[1] = 1'b0;
        rsp_ready    = 1'b1;
        step();
        req_valid = '0;
        step();

        // mixed patterns with intermittent backpressure
        for (int k = 0; k < 300; k++) begin
            req_valid = 4'($urandom);
            req_op    = 12'($urandom);
            req_a     = {$urandom, $urandom};
            req_b     = {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 3) != 0);
            reset     = (k == 150);
            step();
        end
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        step();

`ifdef LU_OPCOUNT_EN
        reset = 1'b1;
        step();
        chk("cnt_reset", 32'(op_count), 32'd0);
        reset = 1'b0;
        setreq(0, 3'b000, 16'hFFFF, 16'h1234);
        repeat (3) step();
        chk("cnt_three", 32'(op_count), 32'd3);
        repeat (65540) step();
        chk("cnt_saturate", 32'(op_count), 32'hFFFF);
        req_valid = '0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
